// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and width defaults for the sequential restoring divider.
// Optional build macro: SIGNED_DIV_EN (two's-complement operands, adds the FIX state).
package div_pkg;

    localparam int DIVIDEND_W_DEF = 12;
    localparam int DIVISOR_W_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake bundle between a requester and the divider.
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division iteration: shift {P,Q} left, subtract D when it fits.
module div_step #(
    parameter int DIVIDEND_W = 12,
    parameter int DIVISOR_W  = 6
) (
    input  logic [DIVISOR_W:0]    p_in,
    input  logic [DIVIDEND_W-1:0] q_in,
    input  logic [DIVISOR_W-1:0]  d_in,
    output logic [DIVISOR_W:0]    p_out,
    output logic [DIVIDEND_W-1:0] q_out
);
    typedef logic [DIVISOR_W+1:0] wide_t;
    typedef logic [DIVISOR_W:0]   p_t;

    wide_t p_sh;
    wide_t d_ext;
    logic  fits;

    // The extra top bit keeps the shifted value exact, so the compare is the sign of T.
    always_comb begin
        p_sh  = {p_in, q_in[DIVIDEND_W-1]};
        d_ext = wide_t'(d_in);
        fits  = (p_sh >= d_ext);
        p_out = fits ? p_t'(p_sh - d_ext) : p_sh[DIVISOR_W:0];
        q_out = {q_in[DIVIDEND_W-2:0], fits};
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Optional build macro: SIGNED_DIV_EN (two's-complement operands via sign/magnitude and a FIX state).
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_divider_if.slave  bus
);
    localparam int CW = cnt_width(DIVIDEND_W);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(DIVIDEND_W - 1);

    state_t                state_reg, state_next;
    logic                  accept, finish, busy, divisor_zero;
    logic [DIVISOR_W:0]    p_reg, p_step;
    logic [DIVIDEND_W-1:0] q_reg, q_step;
    logic [DIVISOR_W-1:0]  d_reg;
    cnt_t                  cnt_reg;
    logic                  dbz_reg;
    logic [DIVIDEND_W-1:0] quotient_reg;
    logic [DIVISOR_W-1:0]  remainder_reg;
    logic                  done_reg, div_by_zero_reg;
    logic [DIVIDEND_W-1:0] dividend_mag;
    logic [DIVISOR_W-1:0]  divisor_mag;

`ifdef SIGNED_DIV_EN
    logic sign_n_reg, sign_d_reg;

    always_comb begin
        dividend_mag = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
        divisor_mag  = bus.divisor[DIVISOR_W-1]   ? -bus.divisor  : bus.divisor;
    end
`else
    always_comb begin
        dividend_mag = bus.dividend;
        divisor_mag  = bus.divisor;
    end
`endif

    assign divisor_zero = (bus.divisor == '0);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = divisor_zero ? DONE : RUN;
`ifdef SIGNED_DIV_EN
            RUN:  if (cnt_reg == LAST) state_next = FIX;
            FIX:  state_next = DONE;
`else
            RUN:  if (cnt_reg == LAST) state_next = DONE;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The done-pulse cycle is already IDLE, so start is masked there explicitly.
    always_comb begin
        busy   = (state_reg != IDLE);
        accept = (state_reg == IDLE) && bus.start && !done_reg;
        finish = (state_reg == DONE);
    end

    div_step #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W)) u_step (
        .p_in  (p_reg),
        .q_in  (q_reg),
        .d_in  (d_reg),
        .p_out (p_step),
        .q_out (q_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            cnt_reg         <= '0;
            dbz_reg         <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
`ifdef SIGNED_DIV_EN
            sign_n_reg      <= 1'b0;
            sign_d_reg      <= 1'b0;
`endif
        end else begin
            done_reg <= finish;
            if (accept) begin
                p_reg           <= '0;
                q_reg           <= divisor_zero ? '1 : dividend_mag;
                d_reg           <= divisor_mag;
                cnt_reg         <= '0;
                dbz_reg         <= divisor_zero;
                quotient_reg    <= '0;
                remainder_reg   <= '0;
                div_by_zero_reg <= 1'b0;
`ifdef SIGNED_DIV_EN
                sign_n_reg      <= bus.dividend[DIVIDEND_W-1];
                sign_d_reg      <= bus.divisor[DIVISOR_W-1];
`endif
            end else begin
                case (state_reg)
                    RUN: begin
                        p_reg   <= p_step;
                        q_reg   <= q_step;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`ifdef SIGNED_DIV_EN
                    FIX: begin
                        q_reg <= (sign_n_reg ^ sign_d_reg) ? -q_reg : q_reg;
                        p_reg <= {1'b0, sign_n_reg ? -p_reg[DIVISOR_W-1:0] : p_reg[DIVISOR_W-1:0]};
                    end
`endif
                    DONE: begin
                        quotient_reg    <= q_reg;
                        remainder_reg   <= p_reg[DIVISOR_W-1:0];
                        div_by_zero_reg <= dbz_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.busy        = busy;
    assign bus.done        = done_reg;
    assign bus.div_by_zero = div_by_zero_reg;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (12-bit dividend, 6-bit divisor).
module tb_seq_restoring_divider;
`ifdef SIGNED_DIV_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 13;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   lat;
    int   pulses;

    seq_restoring_divider_if #(.DIVIDEND_W(12), .DIVISOR_W(6)) bus ();

    seq_restoring_divider #(.DIVIDEND_W(12), .DIVISOR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [11:0] a, input logic [5:0] b,
                          input logic [11:0] eq, input logic [5:0] er, input logic ez, input int elat);
        int n;
        int busy_cnt;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, " clear_flag"}, 32'(bus.div_by_zero), 32'd0);
        n = 0;
        busy_cnt = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            n++;
        end
        check({tag, " latency"}, n, elat);
        check({tag, " busy_cycles"}, busy_cnt, elat);
        check({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(ez));
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        tick();
        check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, " q_hold"}, 32'(bus.quotient), 32'(eq));
        $display("[TB] %s: %0d / %0d -> q=%0h r=%0h dbz=%0d lat=%0d", tag, a, b,
                 bus.quotient, bus.remainder, bus.div_by_zero, n);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset quotient", 32'(bus.quotient), 32'd0);
        check("reset remainder", 32'(bus.remainder), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset dbz", 32'(bus.div_by_zero), 32'd0);

        run_op("100/7", 12'd100, 6'd7, 12'd14, 6'd2, 1'b0, LAT);
`ifndef SIGNED_DIV_EN
        run_op("4095/63", 12'd4095, 6'd63, 12'd65, 6'd0, 1'b0, LAT);
        run_op("5/63", 12'd5, 6'd63, 12'd0, 6'd5, 1'b0, LAT);
`endif
        run_op("0/5", 12'd0, 6'd5, 12'd0, 6'd0, 1'b0, LAT);

        run_op("50/0", 12'd50, 6'd0, 12'hFFF, 6'd0, 1'b1, 1);
        tick();
        check("dbz hold", 32'(bus.div_by_zero), 32'd1);
        run_op("10/3", 12'd10, 6'd3, 12'd3, 6'd1, 1'b0, LAT);

        // start held high for the whole operation with different operands
        bus.dividend = 12'd100;
        bus.divisor  = 6'd7;
        bus.start    = 1'b1;
        tick();
        bus.dividend = 12'd9;
        bus.divisor  = 6'd2;
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        check("held_start latency", lat, LAT);
        check("held_start quotient", 32'(bus.quotient), 32'd14);
        check("held_start remainder", 32'(bus.remainder), 32'd2);
        tick();
        check("held_start no_accept_on_done busy", 32'(bus.busy), 32'd0);
        check("held_start single_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        $display("[TB] held start: q=%0h r=%0h", bus.quotient, bus.remainder);
        tick();

        // reset in the middle of an operation
        bus.dividend = 12'd100;
        bus.divisor  = 6'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort quotient", 32'(bus.quotient), 32'd0);
        check("abort remainder", 32'(bus.remainder), 32'd0);
        check("abort dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            tick();
            if (bus.done) pulses++;
        end
        check("abort no_done", pulses, 0);
        $display("[TB] abort: busy=%0d pulses=%0d", bus.busy, pulses);
        run_op("20/6", 12'd20, 6'd6, 12'd3, 6'd2, 1'b0, LAT);

`ifdef SIGNED_DIV_EN
        run_op("-100/7", 12'hF9C, 6'd7, 12'hFF2, 6'h3E, 1'b0, LAT);
        run_op("100/-7", 12'd100, 6'h39, 12'hFF2, 6'd2, 1'b0, LAT);
        run_op("-2048/-1", 12'h800, 6'h3F, 12'h800, 6'd0, 1'b0, LAT);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
